// File: rtl/jtcontra_rom_arb.sv
// One-entry read caches for the main and sound CPUs in front of a shared SDRAM read port.
// Optional macro JTCONTRA_ROMARB_PRIO_EN: main wins simultaneous misses (default is round-robin).
module jtcontra_rom_arb (
  input  logic        clk,
  input  logic        rstn,
  input  logic        main_cs,
  input  logic [16:0] main_addr,
  output logic        main_ok,
  output logic [7:0]  main_data,
  input  logic        snd_cs,
  input  logic [14:0] snd_addr,
  output logic        snd_ok,
  output logic [7:0]  snd_data,
  output logic        sdram_req,
  output logic [17:0] sdram_addr,
  input  logic [7:0]  sdram_data,
  input  logic        sdram_ok,
  output logic [1:0]  state_dbg
);

  // Handshake: sdram_req is a level held with a stable sdram_addr until the one-cycle
  // sdram_ok strobe; xx_ok is a combinational cache hit, valid only while xx_cs is high.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, FILL = 2'd2} state_t;

  state_t      st_q, st_d;
  logic        gnt_q, gnt_d;
  logic        rr_q, rr_d;
  logic        req_q, req_d;
  logic [17:0] addr_q, addr_d;
  logic [7:0]  buf_q, buf_d;
  logic        main_vld_q, main_vld_d;
  logic [16:0] main_tag_q, main_tag_d;
  logic [7:0]  main_dat_q, main_dat_d;
  logic        snd_vld_q, snd_vld_d;
  logic [14:0] snd_tag_q, snd_tag_d;
  logic [7:0]  snd_dat_q, snd_dat_d;
  logic        main_pend_q, main_pend_d;
  logic        snd_pend_q, snd_pend_d;
  logic        main_hit, snd_hit, main_miss, snd_miss;
  logic        pick, start;

  assign main_hit   = main_vld_q & (main_addr == main_tag_q);
  assign snd_hit    = snd_vld_q & (snd_addr == snd_tag_q);
  assign main_ok    = main_cs & main_hit;
  assign snd_ok     = snd_cs & snd_hit;
  assign main_miss  = main_cs & ~main_hit;
  assign snd_miss   = snd_cs & ~snd_hit;
  assign main_data  = main_dat_q;
  assign snd_data   = snd_dat_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign state_dbg  = st_q;

  // pick: 0 selects main, 1 selects sound
  always_comb begin
`ifdef JTCONTRA_ROMARB_PRIO_EN
    pick = ~main_pend_q;
`else
    pick = (main_pend_q & snd_pend_q) ? rr_q : snd_pend_q;
`endif
  end

  assign start = (st_q == IDLE) & (main_pend_q | snd_pend_q);

  // A requester is not re-marked pending while its own transaction is in flight.
  always_comb begin
    main_pend_d = main_miss & ~(start & ~pick) & ~((st_q != IDLE) & ~gnt_q);
    snd_pend_d  = snd_miss & ~(start & pick) & ~((st_q != IDLE) & gnt_q);
  end

  always_comb begin
    st_d       = st_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    req_d      = req_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    main_vld_d = main_vld_q;
    main_tag_d = main_tag_q;
    main_dat_d = main_dat_q;
    snd_vld_d  = snd_vld_q;
    snd_tag_d  = snd_tag_q;
    snd_dat_d  = snd_dat_q;
    case (st_q)
      IDLE: begin
        if (start) begin
          gnt_d  = pick;
          rr_d   = ~pick;
          addr_d = pick ? {3'b100, snd_addr} : {1'b0, main_addr};
          req_d  = 1'b1;
          st_d   = WAIT;
        end
      end
      WAIT: begin
        if (sdram_ok) begin
          buf_d = sdram_data;
          req_d = 1'b0;
          st_d  = FILL;
        end
      end
      FILL: begin
        if (gnt_q) begin
          snd_vld_d = 1'b1;
          snd_tag_d = addr_q[14:0];
          snd_dat_d = buf_q;
        end else begin
          main_vld_d = 1'b1;
          main_tag_d = addr_q[16:0];
          main_dat_d = buf_q;
        end
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q        <= IDLE;
      gnt_q       <= 1'b0;
      rr_q        <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= 18'd0;
      buf_q       <= 8'hFF;
      main_vld_q  <= 1'b0;
      main_tag_q  <= 17'd0;
      main_dat_q  <= 8'hFF;
      snd_vld_q   <= 1'b0;
      snd_tag_q   <= 15'd0;
      snd_dat_q   <= 8'hFF;
      main_pend_q <= 1'b0;
      snd_pend_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      buf_q       <= buf_d;
      main_vld_q  <= main_vld_d;
      main_tag_q  <= main_tag_d;
      main_dat_q  <= main_dat_d;
      snd_vld_q   <= snd_vld_d;
      snd_tag_q   <= snd_tag_d;
      snd_dat_q   <= snd_dat_d;
      main_pend_q <= main_pend_d;
      snd_pend_q  <= snd_pend_d;
    end
  end

endmodule

// File: tb/tb_jtcontra_rom_arb.sv
// Bench for jtcontra_rom_arb: directed scenarios, SDRAM responder, event scoreboard.
module tb_jtcontra_rom_arb;
  localparam int W = 37;
  localparam int SD_LAT = 4;
  localparam logic [1:0] K_REQ = 2'd0, K_MAIN = 2'd1, K_SND = 2'd2;

  logic        clk, rstn;
  logic        main_cs, snd_cs, main_ok, snd_ok, sdram_req, sdram_ok;
  logic [16:0] main_addr;
  logic [14:0] snd_addr;
  logic [7:0]  main_data, snd_data, sdram_data;
  logic [17:0] sdram_addr;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int stray_cnt = 0;
  bit sd_auto = 1'b1;
  logic [W-1:0] exp_q[$];

  jtcontra_rom_arb dut (
    .clk(clk), .rstn(rstn),
    .main_cs(main_cs), .main_addr(main_addr), .main_ok(main_ok), .main_data(main_data),
    .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_ok(snd_ok), .snd_data(snd_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_data(sdram_data),
    .sdram_ok(sdram_ok), .state_dbg(state_dbg)
  );

  // clock / cycle counter / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100us");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] sd_byte(input logic [17:0] a);
    return (a == 18'h08000) ? 8'h5A : (a[7:0] ^ 8'hC3);
  endfunction

  function automatic logic [W-1:0] ev(input bit chk, input int c, input logic [1:0] k,
                                      input logic [17:0] v);
    logic [31:0] cv;
    cv = c;
    return {chk, cv[15:0], k, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic got(input logic [W-1:0] a);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d val %0h at cycle %0d, expected none",
               a[19:18], a[17:0], cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind_val", {12'd0, a[19:0]}, {12'd0, e[19:0]});
      if (e[W-1]) check("event_cycle", {16'd0, a[35:20]}, {16'd0, e[35:20]});
    end
  endtask

  // SDRAM responder: strobes ok SD_LAT cycles after req rises, or one stray strobe on demand
  initial begin : sdram_model
    int age;
    int stray_seen;
    age = 0;
    stray_seen = 0;
    sdram_ok = 1'b0;
    sdram_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      sdram_ok = 1'b0;
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        sdram_ok = 1'b1;
        sdram_data = 8'h77;
        age = 0;
      end else if (sd_auto && sdram_req) begin
        age++;
        if (age == SD_LAT) begin
          sdram_ok = 1'b1;
          sdram_data = sd_byte(sdram_addr);
        end
      end else begin
        age = 0;
      end
    end
  end

  // monitor: every rising edge of sdram_req / main_ok / snd_ok is an event checked in order
  initial begin : monitor
    logic req_p, mok_p, sok_p;
    req_p = 1'b0;
    mok_p = 1'b0;
    sok_p = 1'b0;
    forever begin
      @(negedge clk);
      if (sdram_req && !req_p) got(ev(1'b0, cyc, K_REQ, sdram_addr));
      if (main_ok && !mok_p)   got(ev(1'b0, cyc, K_MAIN, {10'd0, main_data}));
      if (snd_ok && !sok_p)    got(ev(1'b0, cyc, K_SND, {10'd0, snd_data}));
      req_p = sdram_req;
      mok_p = main_ok;
      sok_p = snd_ok;
    end
  end

  task automatic wait_for(input int which, input int max, input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < max && !hit; n++) begin
      @(negedge clk);
      case (which)
        0: hit = sdram_req;
        1: hit = !sdram_req;
        2: hit = main_ok;
        3: hit = snd_ok;
        default: hit = main_ok && snd_ok;
      endcase
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL timeout_%s: condition not seen within %0d cycles, required it", name, max);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin : stimulus
    int k;
    rstn = 1'b0;
    main_cs = 1'b0;
    snd_cs = 1'b0;
    main_addr = 17'd0;
    snd_addr = 15'd0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_req", sdram_req, 1'b0);
    check("rst_addr", sdram_addr, 18'd0);
    check("rst_main_data", main_data, 8'hFF);
    check("rst_snd_data", snd_data, 8'hFF);
    check("rst_state", state_dbg, 2'd0);
    @(posedge clk);
    #1;
    main_cs = 1'b1;
    snd_cs = 1'b1;
    #1;
    check("rst_main_ok_tag0", main_ok, 1'b0);
    check("rst_snd_ok_tag0", snd_ok, 1'b0);
    #1;
    main_cs = 1'b0;
    snd_cs = 1'b0;

    // main miss, 4-cycle SDRAM latency -> ok 7 clk after the miss
    @(posedge clk);
    #1;
    k = cyc;
    exp_q.push_back(ev(1'b1, k + 2, K_REQ, 18'h08000));
    exp_q.push_back(ev(1'b1, k + 7, K_MAIN, 18'h0005A));
    main_addr = 17'h08000;
    main_cs = 1'b1;
    wait_for(2, 20, "main_miss");
    @(posedge clk);
    #1 main_cs = 1'b0;

    // main re-hit: same-cycle ok, no SDRAM traffic
    @(posedge clk);
    #1;
    k = cyc;
    exp_q.push_back(ev(1'b1, k, K_MAIN, 18'h0005A));
    main_cs = 1'b1;
    #1 check("rehit_same_cycle", main_ok, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("rehit_no_req", sdram_req, 1'b0);
    end
    @(posedge clk);
    #1 main_cs = 1'b0;

    // simultaneous misses after reset: main first, then sound
    do_reset();
    @(posedge clk);
    #1;
    exp_q.push_back(ev(1'b0, 0, K_REQ, 18'h00010));
    exp_q.push_back(ev(1'b0, 0, K_MAIN, 18'h000D3));
    exp_q.push_back(ev(1'b0, 0, K_REQ, 18'h20123));
    exp_q.push_back(ev(1'b0, 0, K_SND, 18'h000E0));
    main_addr = 17'h00010;
    snd_addr = 15'h0123;
    main_cs = 1'b1;
    snd_cs = 1'b1;
    wait_for(3, 40, "pair1");
    @(posedge clk);
    #1;
    main_cs = 1'b0;
    snd_cs = 1'b0;

    // a lone main grant, then a second simultaneous pair
    @(posedge clk);
    #1;
    exp_q.push_back(ev(1'b0, 0, K_REQ, 18'h00020));
    exp_q.push_back(ev(1'b0, 0, K_MAIN, 18'h000E3));
    main_addr = 17'h00020;
    main_cs = 1'b1;
    wait_for(2, 20, "main_single");
    @(posedge clk);
    #1;
    main_cs = 1'b0;
    @(posedge clk);
    #1;
`ifdef JTCONTRA_ROMARB_PRIO_EN
    exp_q.push_back(ev(1'b0, 0, K_REQ, 18'h00030));
    exp_q.push_back(ev(1'b0, 0, K_MAIN, 18'h000F3));
    exp_q.push_back(ev(1'b0, 0, K_REQ, 18'h20040));
    exp_q.push_back(ev(1'b0, 0, K_SND, 18'h00083));
`else
    exp_q.push_back(ev(1'b0, 0, K_REQ, 18'h20040));
    exp_q.push_back(ev(1'b0, 0, K_SND, 18'h00083));
    exp_q.push_back(ev(1'b0, 0, K_REQ, 18'h00030));
    exp_q.push_back(ev(1'b0, 0, K_MAIN, 18'h000F3));
`endif
    main_addr = 17'h00030;
    snd_addr = 15'h0040;
    main_cs = 1'b1;
    snd_cs = 1'b1;
    wait_for(4, 60, "pair2");
    @(posedge clk);
    #1;
    main_cs = 1'b0;
    snd_cs = 1'b0;

    // address change during WAIT: fill keeps the old tag, a new request follows
    @(posedge clk);
    #1;
    exp_q.push_back(ev(1'b0, 0, K_REQ, 18'h00010));
    main_addr = 17'h00010;
    main_cs = 1'b1;
    wait_for(0, 20, "chg_req1");
    @(posedge clk);
    #1;
    exp_q.push_back(ev(1'b0, 0, K_REQ, 18'h00011));
    exp_q.push_back(ev(1'b0, 0, K_MAIN, 18'h000D2));
    main_addr = 17'h00011;
    wait_for(1, 20, "chg_req_low");
    wait_for(0, 20, "chg_req2");
    check("chg_no_ok_old_tag", main_ok, 1'b0);
    check("chg_fill_data", main_data, 8'hD3);
    wait_for(2, 20, "chg_ok");
    @(posedge clk);
    #1 main_cs = 1'b0;

    // reset in WAIT, then a stray sdram_ok after release
    sd_auto = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(ev(1'b0, 0, K_REQ, 18'h00050));
    main_addr = 17'h00050;
    main_cs = 1'b1;
    wait_for(0, 20, "rw_req");
    @(posedge clk);
    #1 main_cs = 1'b0;
    #1 rstn = 1'b0;
    #1;
    check("rw_req_cleared", sdram_req, 1'b0);
    check("rw_addr_cleared", sdram_addr, 18'd0);
    check("rw_state_idle", state_dbg, 2'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    stray_cnt++;
    repeat (3) begin
      @(negedge clk);
      check("rw_stray_no_req", sdram_req, 1'b0);
    end
    @(posedge clk);
    #1;
    main_cs = 1'b1;
    snd_cs = 1'b1;
    snd_addr = 15'h0000;
    #1;
    check("rw_main_ok", main_ok, 1'b0);
    check("rw_snd_ok", snd_ok, 1'b0);
    check("rw_no_cache_write", main_data, 8'hFF);
    #1;
    main_cs = 1'b0;
    snd_cs = 1'b0;
    sd_auto = 1'b1;

    // drain and report
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
